// File: rtl/riscv_pkg.sv
// Shared types and constants for the commit trace buffer: serializer states,
// the captured retire record, HDR word field positions and word counts.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PC    = 3'd2,
        ST_INSTR = 3'd3,
        ST_REG   = 3'd4,
        ST_MADDR = 3'd5,
        ST_MDATA = 3'd6
    } trace_state_e;

    typedef struct packed {
        logic [7:0]  seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  reg_addr;
        logic [31:0] reg_data;
        logic        mem_wrt;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    // HDR layout: [31:24] seq, [23] mem_wrt, [22] reg_wr, [21:17] reg_addr,
    // [16:3] zero, [2:0] number of words following HDR.
    localparam int HDR_SEQ_LSB   = 24;
    localparam int HDR_MEMWR_BIT = 23;
    localparam int HDR_REGWR_BIT = 22;
    localparam int HDR_RADDR_LSB = 17;
    localparam int HDR_CNT_LSB   = 0;

    // PC and INSTR always follow HDR; REG adds one word, a store adds two.
    localparam logic [2:0] WORDS_BASE = 3'd2;
    localparam logic [2:0] WORDS_REG  = 3'd1;
    localparam logic [2:0] WORDS_MEM  = 3'd2;

    function automatic logic [31:0] make_hdr(input trace_rec_t r);
        logic [31:0] h;
        logic        reg_wr;
        logic [2:0]  cnt;
        reg_wr = (r.reg_addr != 5'd0);
        cnt    = WORDS_BASE + (reg_wr ? WORDS_REG : 3'd0) + (r.mem_wrt ? WORDS_MEM : 3'd0);
        h      = '0;
        h[HDR_SEQ_LSB +: 8]   = r.seq;
        h[HDR_MEMWR_BIT]      = r.mem_wrt;
        h[HDR_REGWR_BIT]      = reg_wr;
        h[HDR_RADDR_LSB +: 5] = r.reg_addr;
        h[HDR_CNT_LSB +: 3]   = cnt;
        return h;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO: power-of-two depth, wrapping pointers, occupancy count 0..DEPTH.
// Storage is not reset; only pointers and count are.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full blocks a push even when a pop happens on the same edge.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Record storage write port.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures one record per retired instruction into a
// FIFO and serializes each record as a 3..6 word stream with a handshake.
//
// state   | meaning
// IDLE    | nothing queued, tvalid low
// HDR     | header word of the head record
// PC      | retired PC
// INSTR   | instruction word
// REG     | write-back data (only when reg_addr != 0)
// MADDR   | store address (only when mem_wrt)
// MDATA   | store data (only when mem_wrt)
module commit_trace_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              retire_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       instr_i,
    input  logic [4:0]        reg_addr_i,
    input  logic [31:0]       reg_data_i,
    input  logic              mem_wrt_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       tdata_o,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic              tlast_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    trace_state_e      state_q, state_d, after_last;
    logic [7:0]        seq_q, seq_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_q, ovf_d;

    trace_rec_t        wr_rec, head;
    logic [REC_W-1:0]  fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              push, pop, xfer;

    assign push = retire_i & ~fifo_full & ~rst_i;
    assign xfer = tvalid_o & tready_i;
    assign pop  = xfer & tlast_o;
    assign head = trace_rec_t'(fifo_rdata);

    // Pack the retire inputs into a record tagged with the current seq.
    always_comb begin
        wr_rec          = '0;
        wr_rec.seq      = seq_q;
        wr_rec.pc       = pc_i;
        wr_rec.instr    = instr_i;
        wr_rec.reg_addr = reg_addr_i;
        wr_rec.reg_data = reg_data_i;
        wr_rec.mem_wrt  = mem_wrt_i;
        wr_rec.mem_addr = mem_addr_i;
        wr_rec.mem_data = mem_data_i;
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_rec),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Sequence number and drop accounting; seq advances on every retire.
    always_comb begin
        seq_d  = seq_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (retire_i) begin
            seq_d = seq_q + 8'd1;
            if (fifo_full) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    // Serializer next state and word mux; outputs depend only on registered state.
    always_comb begin
        state_d    = state_q;
        tdata_o    = '0;
        tlast_o    = 1'b0;
        after_last = (fifo_cnt > CNT_W'(1)) ? ST_HDR : ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_HDR;
            end
            ST_HDR: begin
                tdata_o = make_hdr(head);
                if (xfer) state_d = ST_PC;
            end
            ST_PC: begin
                tdata_o = head.pc;
                if (xfer) state_d = ST_INSTR;
            end
            ST_INSTR: begin
                tdata_o = head.instr;
                tlast_o = (head.reg_addr == 5'd0) && !head.mem_wrt;
                if (xfer) begin
                    if (head.reg_addr != 5'd0) state_d = ST_REG;
                    else if (head.mem_wrt)     state_d = ST_MADDR;
                    else                       state_d = after_last;
                end
            end
            ST_REG: begin
                tdata_o = head.reg_data;
                tlast_o = !head.mem_wrt;
                if (xfer) state_d = head.mem_wrt ? ST_MADDR : after_last;
            end
            ST_MADDR: begin
                tdata_o = head.mem_addr;
                if (xfer) state_d = ST_MDATA;
            end
            ST_MDATA: begin
                tdata_o = head.mem_data;
                tlast_o = 1'b1;
                if (xfer) state_d = after_last;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tvalid_o   = (state_q != ST_IDLE);
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;

    // State, sequence and drop registers; reset abandons any record in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of record slots (power of two, 2..64).
REQ-002 The block SHALL have parameter DROP_W, default 16, meaning the width of the drop counter.
REQ-003 Port `clk_i`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port `rst_i`: input, 1 bit, synchronous, active-high reset.
REQ-005 Port `retire_i`: input, 1 bit, one-cycle strobe marking that one instruction retired this cycle.
REQ-006 Ports `pc_i` and `instr_i`: input, 32 bits each, the retired PC and instruction word.
REQ-007 Ports `reg_addr_i` (input, 5 bits) and `reg_data_i` (input, 32 bits): register write-back; `reg_addr_i` = 0 means no write.
REQ-008 Ports `mem_wrt_i` (input, 1 bit), `mem_addr_i` (input, 32 bits) and `mem_data_i` (input, 32 bits): data-memory store information.
REQ-009 Port `tdata_o`: output, 32 bits, serialized trace word.
REQ-010 Ports `tvalid_o` (output, 1 bit), `tready_i` (input, 1 bit) and `tlast_o` (output, 1 bit): word handshake; `tlast_o` marks the final word of a record.
REQ-011 Ports `overflow_o` (output, 1 bit, sticky) and `drop_cnt_o` (output, DROP_W bits): indicate dropped records.

Function
REQ-012 On each `clk_i` edge with `retire_i`=1, the block SHALL capture one record {seq, pc, instr, reg_addr, reg_data, mem_wrt, mem_addr, mem_data} into the FIFO, if the FIFO is not full.
REQ-013 `seq` SHALL be an 8-bit counter that increments on every `retire_i` (accepted or dropped) and wraps 255->0; a captured record carries the pre-increment value.
REQ-014 A record SHALL be serialized in this order: HDR, PC, INSTR, then REG only if `reg_addr` != 0, then MADDR and MDATA only if `mem_wrt`=1.
REQ-015 HDR SHALL be laid out as: [31:24] seq, [23] mem_wrt, [22] reg_wr, [21:17] reg_addr, [16:3] zero, [2:0] count of words following HDR (2..5).
REQ-016 A word SHALL transfer on a cycle with `tvalid_o` & `tready_i`; `tdata_o`, `tlast_o` and `tvalid_o` SHALL stay stable while `tvalid_o`=1 and `tready_i`=0.
REQ-017 The FSM SHALL have states IDLE, HDR, PC, INSTR, REG, MADDR and MDATA; IDLE->HDR when the FIFO is non-empty; each state advances on transfer to the next applicable state; after the last word it goes to HDR if another record is queued, else IDLE.
REQ-018 The FIFO SHALL pop the head record at the transfer of its `tlast_o` word.
REQ-019 Latency SHALL be: a record captured at edge N drives `tvalid_o`=1 with its HDR no earlier than the cycle after edge N; there is no combinational path from retire inputs to outputs.
REQ-020 If the FIFO is full at the edge, the record SHALL be dropped, with no bypass even if a slot is popped on that same edge.
REQ-021 On a drop, `drop_cnt_o` SHALL increment, saturating at all-ones, and `overflow_o` SHALL be set to 1 and held until reset.
REQ-022 When a push and a pop occur on the same edge with the FIFO not full, both SHALL occur and the occupancy SHALL be unchanged.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH, with full/empty determined by an occupancy count 0..DEPTH.
REQ-024 `tvalid_o` SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-025 While `rst_i`=1 at an edge, the block SHALL set: state IDLE, FIFO empty, seq=0, `tvalid_o`=0, `tlast_o`=0, `tdata_o`=0, `overflow_o`=0, `drop_cnt_o`=0.
REQ-026 A reset asserted mid-record SHALL abandon that record without emitting `tlast_o`, and SHALL ignore `retire_i` during that cycle.
REQ-027 FIFO storage contents SHALL NOT require reset.

Structure
REQ-028 The state enum, the HDR field positions and the word-count constants SHALL reside in `riscv_pkg`.
REQ-029 Storage SHALL be one sub-module, `trace_fifo` (parameterized width/depth, push/pop/full/empty/count); the serializer FSM SHALL live in the top.

Verification
REQ-030 Scenario: with `tready_i`=1, one retire of pc=0x0000_0010, instr=0x0050_0093, reg_addr=1, reg_data=5, mem_wrt=0 -> exactly 4 words: HDR 0x0042_0003, 0x10, 0x0050_0093, 5, with `tlast_o` on the 4th word.
REQ-031 Scenario: a store retire with mem_wrt=1, reg_addr=0, mem_addr=0x100, mem_data=0xDEAD_BEEF -> HDR[2:0]=4, [23]=1, words PC, INSTR, 0x100, 0xDEAD_BEEF, no REG word.
REQ-032 Scenario: `tready_i`=0 and 10 consecutive retires with DEPTH=8 -> 8 records stored, `drop_cnt_o`=2, `overflow_o`=1; after `tready_i`=1 the seqs are 0..7 in order.
REQ-033 Scenario: `tready_i` toggled randomly -> no word is lost or duplicated and `tdata_o` is held stable during stalls.
REQ-034 Scenario: 300 retires with no drops -> the HDR seq wraps 255->0 and outputs 0..255, 0..43.
REQ-035 Scenario: `rst_i` asserted during the INSTR word -> next cycle `tvalid_o`=0 and the counters read 0; the first record after reset has seq=0.
